// File: rtl/uart_rx_if.sv
// Bundles the receiver's baud/line/ack inputs and its data/status outputs.
// The master drives the line side; the receiver attaches through the slave modport.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 serial_in;
    logic                 rx_ack;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 framing_error;
    logic                 overrun;
    logic                 busy;

    modport master (
        output baud_tick, serial_in, rx_ack,
        input  data_out, data_valid, framing_error, overrun, busy
    );

    modport slave (
        input  baud_tick, serial_in, rx_ack,
        output data_out, data_valid, framing_error, overrun, busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start bit, DATA_BITS data bits LSB first, 1 stop bit.
// Samples at mid-bit and holds the last word until the consumer acknowledges it.
module uart_rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input logic   clk,
    input logic   reset,
    uart_rx_if.slave bus
);
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
    localparam logic [TickW-1:0] MidTick  = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] LastTick = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e               state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 rx_meta_q, rxs_q, rx_prev_q;
    logic [1:0]           settle_q;
    logic                 armed_q;
    logic                 falling;
    logic                 complete;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            settle_q  <= 2'b00;
        end else begin
            rx_meta_q <= bus.serial_in;
            rxs_q     <= rx_meta_q;
            settle_q  <= {settle_q[0], 1'b1};
        end
    end

    // The synchronizer resets to 1, so a line held low through reset would look like a
    // falling edge; start detection stays disarmed until a genuine high sample is seen.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_prev_q <= 1'b1;
            armed_q   <= 1'b0;
        end else if (bus.baud_tick) begin
            rx_prev_q <= rxs_q;
            if (rxs_q && settle_q[1]) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign falling = armed_q & rx_prev_q & ~rxs_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        complete = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.baud_tick && falling) begin
                    state_d = StStart;
                    tick_d  = '0;
                end
            end
            StStart: begin
                if (bus.baud_tick) begin
                    if (tick_q == MidTick) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rxs_q ? StIdle : StData;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (bus.baud_tick) begin
                    if (tick_q == LastTick) begin
                        tick_d  = '0;
                        shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LastBit) begin
                            state_d = StStop;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (bus.baud_tick) begin
                    if (tick_q == LastTick) begin
                        tick_d   = '0;
                        complete = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Completion takes priority over an acknowledge arriving in the same cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (complete) begin
            data_d  = shift_q;
            ferr_d  = ~rxs_q;
            valid_d = 1'b1;
            if (valid_q && !bus.rx_ack) begin
                ovr_d = 1'b1;
            end
        end else if (bus.rx_ack) begin
            valid_d = 1'b0;
        end
    end

    assign bus.data_out      = data_q;
    assign bus.data_valid    = valid_q;
    assign bus.framing_error = ferr_q;
    assign bus.overrun       = ovr_q;
    assign bus.busy          = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are queued as expectations when sent and a
// monitor compares each completed frame against the queue head.
module tb_uart_rx;
    localparam int unsigned Os      = 16;
    localparam int unsigned TickDiv = 4;
    localparam int unsigned BitClks = Os * TickDiv;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       ovr;
    } exp_t;

    logic clk;
    logic reset;
    logic auto_ack;
    int   checks;
    int   passes;
    exp_t exp_q[$];

    uart_rx_if #(.DATA_BITS(8)) bus();

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(Os)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Baud tick once every TickDiv clocks, changed on the falling edge.
    initial begin
        int unsigned div;
        div = 0;
        bus.baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            bus.baud_tick = (div == TickDiv - 1);
            div = (div + 1) % TickDiv;
        end
    end

    // Acknowledges any valid word for one clock while auto_ack is set.
    initial begin
        bus.rx_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.rx_ack = auto_ack && bus.data_valid && !bus.rx_ack;
        end
    end

    // A frame completes when data_valid rises, or when busy drops with data_valid held.
    initial begin
        logic dv_prev;
        logic busy_prev;
        exp_t e;
        dv_prev   = 1'b0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((!dv_prev && bus.data_valid) ||
                (busy_prev && !bus.busy && bus.data_valid && dv_prev)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {24'd0, bus.data_out}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_data", {24'd0, bus.data_out}, {24'd0, e.data});
                    check("frame_ferr", {31'd0, bus.framing_error}, {31'd0, e.ferr});
                    check("frame_overrun", {31'd0, bus.overrun}, {31'd0, e.ovr});
                    check("frame_busy", {31'd0, bus.busy}, 32'd0);
                end
            end
            dv_prev   = bus.data_valid;
            busy_prev = bus.busy;
        end
    end

    task automatic send_bit(input logic b);
        bus.serial_in = b;
        repeat (BitClks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic ferr, input logic ovr);
        exp_t e;
        e.data = d;
        e.ferr = ferr;
        e.ovr  = ovr;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int bits);
        bus.serial_in = 1'b1;
        repeat (bits * BitClks) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_out"}, {24'd0, bus.data_out}, 32'd0);
        check({tag, "_data_valid"}, {31'd0, bus.data_valid}, 32'd0);
        check({tag, "_framing_error"}, {31'd0, bus.framing_error}, 32'd0);
        check({tag, "_overrun"}, {31'd0, bus.overrun}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] w;
        int         budget;
        checks        = 0;
        passes        = 0;
        auto_ack      = 1'b1;
        reset         = 1'b0;
        bus.serial_in = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("reset");
        idle(1);

        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1);
        check("a5_busy_after", {31'd0, bus.busy}, 32'd0);
        idle(1);

        // Short low pulse: start detected, then rejected at mid-start.
        bus.serial_in = 1'b0;
        repeat (Os) @(negedge clk);
        check("glitch_busy_during", {31'd0, bus.busy}, 32'd1);
        bus.serial_in = 1'b1;
        repeat (BitClks) @(negedge clk);
        check("glitch_busy_after", {31'd0, bus.busy}, 32'd0);
        check("glitch_no_valid", {31'd0, bus.data_valid}, 32'd0);
        idle(1);

        expect_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b0);
        bus.serial_in = 1'b0;
        repeat (3 * BitClks) @(negedge clk);
        check("break_busy", {31'd0, bus.busy}, 32'd0);
        idle(1);
        expect_frame(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1);
        idle(1);

        expect_frame(8'h00, 1'b0, 1'b0);
        expect_frame(8'hFF, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        check("b2b_overrun", {31'd0, bus.overrun}, 32'd0);
        idle(1);

        auto_ack = 1'b0;
        expect_frame(8'h11, 1'b0, 1'b0);
        expect_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(1);
        check("ovr_sticky", {31'd0, bus.overrun}, 32'd1);
        check("ovr_valid_held", {31'd0, bus.data_valid}, 32'd1);
        auto_ack = 1'b1;
        repeat (3) @(negedge clk);
        auto_ack = 1'b0;
        check("ack_clears_valid", {31'd0, bus.data_valid}, 32'd0);
        check("ack_keeps_overrun", {31'd0, bus.overrun}, 32'd1);
        check("ack_keeps_data", {24'd0, bus.data_out}, 32'h22);
        auto_ack = 1'b1;
        idle(1);

        // Reset in the middle of data bit 4 of 0x5A.
        w = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(w[i]);
        bus.serial_in = w[4];
        repeat (BitClks / 2) @(negedge clk);
        pulse_reset();
        check_reset_values("midreset");
        idle(2);
        check("midreset_no_valid", {31'd0, bus.data_valid}, 32'd0);
        expect_frame(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1);
        idle(1);

        // Line low across reset release must not start a frame.
        bus.serial_in = 1'b0;
        pulse_reset();
        repeat (2 * BitClks) @(negedge clk);
        check("lowreset_busy", {31'd0, bus.busy}, 32'd0);
        idle(1);
        expect_frame(8'hC3, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1);
        idle(1);

        budget = 2000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
